// File: rtl/acs_sequencer.sv
// Frame controller for a 4-state Viterbi add-compare-select array: registers and
// normalizes path metrics, streams survivor decisions to memory and reports the best end state.
module acs_sequencer #(
  parameter int PM_W    = 4,
  parameter int ADDR_W  = 5,
  parameter int PM_INIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_frame_len,
  input  logic              i_abort,
  input  logic              i_bm_valid,
  output logic              o_bm_ready,
  input  logic [PM_W-1:0]   i_acs_pm_0,
  input  logic [PM_W-1:0]   i_acs_pm_1,
  input  logic [PM_W-1:0]   i_acs_pm_2,
  input  logic [PM_W-1:0]   i_acs_pm_3,
  input  logic [3:0]        i_acs_dec,
  output logic [PM_W-1:0]   o_pm_0,
  output logic [PM_W-1:0]   o_pm_1,
  output logic [PM_W-1:0]   o_pm_2,
  output logic [PM_W-1:0]   o_pm_3,
  output logic              o_sm_we,
  output logic [ADDR_W-1:0] o_sm_addr,
  output logic [3:0]        o_sm_data,
  output logic              o_busy,
  output logic              o_done,
  input  logic              i_done_ack,
  output logic [1:0]        o_best_state,
  output logic [PM_W-1:0]   o_best_pm
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_FIND,
    ST_DONE
  } state_t;

  state_t                      state, state_nxt;
  logic   [ADDR_W-1:0]         len_q;
  logic   [ADDR_W-1:0]         cnt_q;
  logic   [3:0][PM_W-1:0]      pm_q;
  logic   [3:0][PM_W-1:0]      acs_pm;
  logic   [3:0][PM_W-1:0]      pm_norm;
  logic                        all_msb;
  logic                        accept;
  logic                        last_sym;
  logic   [1:0]                min_idx;
  logic   [PM_W-1:0]           min_val;
  logic   [1:0]                best_state_q;
  logic   [PM_W-1:0]           best_pm_q;

  assign acs_pm   = {i_acs_pm_3, i_acs_pm_2, i_acs_pm_1, i_acs_pm_0};
  assign last_sym = (cnt_q == len_q - ADDR_W'(1));

  // Metrics only ever drift upward; when every state has crossed the half-range
  // point, subtracting that half from all of them keeps the differences intact.
  assign all_msb = acs_pm[0][PM_W-1] & acs_pm[1][PM_W-1] &
                   acs_pm[2][PM_W-1] & acs_pm[3][PM_W-1];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pm_norm[i] = acs_pm[i];
      if (all_msb) pm_norm[i][PM_W-1] = 1'b0;
    end
  end

  // Strict less-than keeps ties on the lowest-numbered state.
  always_comb begin
    min_idx = 2'd0;
    min_val = pm_q[0];
    for (int i = 1; i < 4; i++) begin
      if (pm_q[i] < min_val) begin
        min_idx = 2'(i);
        min_val = pm_q[i];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process ordering.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt  = state;
    o_bm_ready = 1'b0;
    accept     = 1'b0;
    unique case (state)
      ST_IDLE: if (i_start) state_nxt = ST_INIT;
      ST_INIT: begin
        if (i_abort)           state_nxt = ST_IDLE;
        else if (len_q != '0)  state_nxt = ST_RUN;
        else                   state_nxt = ST_FIND;
      end
      ST_RUN: begin
        o_bm_ready = 1'b1;
        if (i_abort) begin
          state_nxt = ST_IDLE;
        end else if (i_bm_valid) begin
          accept = 1'b1;
          if (last_sym) state_nxt = ST_FIND;
        end
      end
      ST_FIND: state_nxt = i_abort ? ST_IDLE : ST_DONE;
      ST_DONE: if (i_done_ack) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    // Handshake outputs must be quiet while reset is held, whatever the state.
    if (!i_rst_n) begin
      o_bm_ready = 1'b0;
      accept     = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      len_q        <= '0;
      cnt_q        <= '0;
      pm_q         <= '0;
      best_state_q <= '0;
      best_pm_q    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (i_start) len_q <= i_frame_len;
        ST_INIT: begin
          pm_q[0] <= '0;
          pm_q[1] <= PM_W'(PM_INIT);
          pm_q[2] <= PM_W'(PM_INIT);
          pm_q[3] <= PM_W'(PM_INIT);
          cnt_q   <= '0;
        end
        ST_RUN: begin
          if (accept) begin
            pm_q  <= pm_norm;
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        ST_FIND: begin
          if (!i_abort) begin
            best_state_q <= min_idx;
            best_pm_q    <= min_val;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_sm_we      = accept;
  assign o_sm_addr    = cnt_q;
  assign o_sm_data    = i_acs_dec;
  assign o_busy       = (state != ST_IDLE);
  assign o_done       = (state == ST_DONE);
  assign o_pm_0       = pm_q[0];
  assign o_pm_1       = pm_q[1];
  assign o_pm_2       = pm_q[2];
  assign o_pm_3       = pm_q[3];
  assign o_best_state = best_state_q;
  assign o_best_pm    = best_pm_q;

endmodule

// File: tb/tb_acs_sequencer.sv
// Self-checking bench for acs_sequencer: directed frames plus randomized frames
// compared against a transaction-level model of metrics, writes and timing.
module tb_acs_sequencer;

  localparam int PM_W    = 4;
  localparam int ADDR_W  = 5;
  localparam int PM_INIT = 4;
  localparam int HALF    = 1 << (PM_W - 1);

  typedef struct packed {
    logic                valid;
    logic [3:0][PM_W-1:0] pm;
    logic [3:0]          dec;
  } sym_t;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_start;
  logic [ADDR_W-1:0] i_frame_len;
  logic              i_abort;
  logic              i_bm_valid;
  logic              o_bm_ready;
  logic [PM_W-1:0]   i_acs_pm_0, i_acs_pm_1, i_acs_pm_2, i_acs_pm_3;
  logic [3:0]        i_acs_dec;
  logic [PM_W-1:0]   o_pm_0, o_pm_1, o_pm_2, o_pm_3;
  logic              o_sm_we;
  logic [ADDR_W-1:0] o_sm_addr;
  logic [3:0]        o_sm_data;
  logic              o_busy;
  logic              o_done;
  logic              i_done_ack;
  logic [1:0]        o_best_state;
  logic [PM_W-1:0]   o_best_pm;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  sym_t stim_q[$];

  acs_sequencer #(.PM_W(PM_W), .ADDR_W(ADDR_W), .PM_INIT(PM_INIT)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_frame_len  (i_frame_len),
    .i_abort      (i_abort),
    .i_bm_valid   (i_bm_valid),
    .o_bm_ready   (o_bm_ready),
    .i_acs_pm_0   (i_acs_pm_0),
    .i_acs_pm_1   (i_acs_pm_1),
    .i_acs_pm_2   (i_acs_pm_2),
    .i_acs_pm_3   (i_acs_pm_3),
    .i_acs_dec    (i_acs_dec),
    .o_pm_0       (o_pm_0),
    .o_pm_1       (o_pm_1),
    .o_pm_2       (o_pm_2),
    .o_pm_3       (o_pm_3),
    .o_sm_we      (o_sm_we),
    .o_sm_addr    (o_sm_addr),
    .o_sm_data    (o_sm_data),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .i_done_ack   (i_done_ack),
    .o_best_state (o_best_state),
    .o_best_pm    (o_best_pm)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic drive_quiet();
    i_start     = 1'b0;
    i_frame_len = '0;
    i_abort     = 1'b0;
    i_bm_valid  = 1'b0;
    i_done_ack  = 1'b0;
    i_acs_pm_0  = '0;
    i_acs_pm_1  = '0;
    i_acs_pm_2  = '0;
    i_acs_pm_3  = '0;
    i_acs_dec   = '0;
  endtask

  task automatic apply_sym(input sym_t s);
    i_bm_valid = s.valid;
    i_acs_pm_0 = s.pm[0];
    i_acs_pm_1 = s.pm[1];
    i_acs_pm_2 = s.pm[2];
    i_acs_pm_3 = s.pm[3];
    i_acs_dec  = s.dec;
  endtask

  function automatic sym_t rand_sym();
    sym_t s;
    bit   high = ($urandom_range(0, 3) == 0);
    s.valid = ($urandom_range(0, 9) < 7);
    for (int i = 0; i < 4; i++)
      s.pm[i] = high ? PM_W'($urandom_range(HALF, 2 * HALF - 1))
                     : PM_W'($urandom_range(0, 2 * HALF - 1));
    s.dec = 4'($urandom_range(0, 15));
    return s;
  endfunction

  function automatic sym_t next_sym();
    if (stim_q.size() != 0) return stim_q.pop_front();
    return rand_sym();
  endfunction

  function automatic sym_t mk_sym(input bit v, input int p0, p1, p2, p3, input int d);
    sym_t s;
    s.valid = v;
    s.pm[0] = PM_W'(p0);
    s.pm[1] = PM_W'(p1);
    s.pm[2] = PM_W'(p2);
    s.pm[3] = PM_W'(p3);
    s.dec   = 4'(d);
    return s;
  endfunction

  // Reference: if every new metric sits in the upper half of the range, all
  // four drop by half the range; otherwise they are taken as-is.
  task automatic model_norm(input sym_t s, output int r[4]);
    bit all_hi = 1'b1;
    for (int i = 0; i < 4; i++) if (int'(s.pm[i]) < HALF) all_hi = 1'b0;
    for (int i = 0; i < 4; i++) r[i] = int'(s.pm[i]) - (all_hi ? HALF : 0);
  endtask

  task automatic check_pm(input string tag, input int e[4]);
    check({tag, "_pm0"}, 32'(o_pm_0), e[0]);
    check({tag, "_pm1"}, 32'(o_pm_1), e[1]);
    check({tag, "_pm2"}, 32'(o_pm_2), e[2]);
    check({tag, "_pm3"}, 32'(o_pm_3), e[3]);
  endtask

  // One frame from start to acknowledge (or abort once abort_after symbols
  // have been accepted). Symbols come from stim_q first, then at random.
  task automatic run_frame(input int len, input int abort_after);
    int   exp_pm[4];
    int   accepted = 0;
    int   stalls   = 0;
    int   best_i;
    sym_t s;

    i_start     = 1'b1;
    i_frame_len = ADDR_W'(len);
    i_abort     = 1'($urandom_range(0, 1));
    #1;
    check("idle_busy", 32'(o_busy), 0);
    check("idle_ready", 32'(o_bm_ready), 0);
    cyc = 0;
    step();
    drive_quiet();
    apply_sym(rand_sym());
    i_bm_valid = 1'b1;
    #1;
    check("init_busy", 32'(o_busy), 1);
    check("init_ready", 32'(o_bm_ready), 0);
    check("init_we", 32'(o_sm_we), 0);
    step();
    exp_pm = '{0, PM_INIT, PM_INIT, PM_INIT};
    check_pm("init", exp_pm);

    while (accepted < len) begin
      if (cyc > 200) begin
        check("run_timeout", accepted, len);
        drive_quiet();
        return;
      end
      s = next_sym();
      apply_sym(s);
      i_start     = 1'($urandom_range(0, 1));
      i_frame_len = ADDR_W'($urandom);
      if (abort_after == accepted) begin
        i_abort    = 1'b1;
        i_bm_valid = 1'b1;
        #1;
        check("abort_ready", 32'(o_bm_ready), 1);
        check("abort_we", 32'(o_sm_we), 0);
        step();
        drive_quiet();
        check("abort_busy", 32'(o_busy), 0);
        check("abort_done", 32'(o_done), 0);
        step();
        check("abort_done_after", 32'(o_done), 0);
        return;
      end
      #1;
      check("run_ready", 32'(o_bm_ready), 1);
      check("run_we", 32'(o_sm_we), 32'(s.valid));
      if (s.valid) begin
        check("run_addr", 32'(o_sm_addr), accepted);
        check("run_data", 32'(o_sm_data), 32'(s.dec));
      end
      step();
      if (s.valid) begin
        model_norm(s, exp_pm);
        accepted++;
      end else begin
        stalls++;
      end
      check_pm("run", exp_pm);
    end

    drive_quiet();
    apply_sym(rand_sym());
    i_bm_valid = 1'b1;
    #1;
    check("find_ready", 32'(o_bm_ready), 0);
    check("find_we", 32'(o_sm_we), 0);
    check("find_done", 32'(o_done), 0);
    step();
    drive_quiet();

    check("done_cycle", cyc, len + 3 + stalls);
    check("done_flag", 32'(o_done), 1);
    best_i = 0;
    for (int i = 1; i < 4; i++) if (exp_pm[i] < exp_pm[best_i]) best_i = i;
    check("best_state", 32'(o_best_state), best_i);
    check("best_pm", 32'(o_best_pm), exp_pm[best_i]);

    repeat ($urandom_range(0, 2)) begin
      i_abort = 1'($urandom_range(0, 1));
      i_start = 1'($urandom_range(0, 1));
      step();
      check("done_hold", 32'(o_done), 1);
      check("done_best_hold", 32'(o_best_pm), exp_pm[best_i]);
      check_pm("done_hold", exp_pm);
    end
    i_abort    = 1'b0;
    i_start    = 1'b0;
    i_done_ack = 1'b1;
    step();
    i_done_ack = 1'b0;
    check("ack_done", 32'(o_done), 0);
    check("ack_busy", 32'(o_busy), 0);
    check("ack_best_state", 32'(o_best_state), best_i);
    check_pm("ack", exp_pm);
  endtask

  task automatic check_reset_state(input string tag);
    int z[4] = '{0, 0, 0, 0};
    check({tag, "_busy"}, 32'(o_busy), 0);
    check({tag, "_done"}, 32'(o_done), 0);
    check({tag, "_best_state"}, 32'(o_best_state), 0);
    check({tag, "_best_pm"}, 32'(o_best_pm), 0);
    check_pm(tag, z);
  endtask

  initial begin
    drive_quiet();
    i_rst_n = 1'b0;
    step();
    step();
    check_reset_state("rst");
    check("rst_ready", 32'(o_bm_ready), 0);
    check("rst_we", 32'(o_sm_we), 0);
    i_rst_n = 1'b1;
    step();

    // Worked example: three symbols, continuous valid.
    stim_q.push_back(mk_sym(1, 1, 5, 6, 7, 'hA));
    stim_q.push_back(mk_sym(1, 2, 3, 7, 8, 'h5));
    stim_q.push_back(mk_sym(1, 4, 3, 9, 9, 'hF));
    run_frame(3, -1);

    // Stalled valid: exactly two writes.
    stim_q.push_back(mk_sym(1, 3, 4, 5, 6, 'h1));
    stim_q.push_back(mk_sym(0, 15, 15, 15, 15, 'hE));
    stim_q.push_back(mk_sym(1, 6, 2, 5, 4, 'h2));
    run_frame(2, -1);

    // Normalization fires, then a vector that must pass through unchanged.
    stim_q.push_back(mk_sym(1, 9, 10, 12, 15, 'h3));
    stim_q.push_back(mk_sym(1, 8, 9, 3, 10, 'h4));
    run_frame(2, -1);

    // Empty frame, then an all-equal tie.
    run_frame(0, -1);
    stim_q.push_back(mk_sym(1, 5, 5, 5, 5, 'h7));
    run_frame(1, -1);

    // Abort after two of four symbols.
    stim_q.push_back(mk_sym(1, 1, 2, 3, 4, 'h8));
    stim_q.push_back(mk_sym(1, 2, 3, 4, 5, 'h9));
    run_frame(4, 2);

    // Reset mid-run.
    i_start     = 1'b1;
    i_frame_len = ADDR_W'(5);
    step();
    drive_quiet();
    step();
    apply_sym(mk_sym(1, 3, 3, 3, 3, 'h6));
    step();
    i_rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(o_bm_ready), 0);
    check("midrst_we", 32'(o_sm_we), 0);
    step();
    drive_quiet();
    check_reset_state("midrst");
    i_rst_n = 1'b1;
    step();

    // Randomized frames.
    for (int f = 0; f < 25; f++) begin
      int len = $urandom_range(0, 12);
      int ab  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 12) : -1;
      if (ab >= len) ab = -1;
      run_frame(len, ab);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acs_sequencer.md
ACS_SEQUENCER -- requirements
Module: acs_sequencer

Interface
REQ-001 Parameter PM_W, default 4, path-metric width in bits.
REQ-002 Parameter ADDR_W, default 5, survivor-memory address width and symbol-counter width.
REQ-003 Parameter PM_INIT, default 4, initial metric of states 1..3 at frame start.
REQ-004 i_clk  in  1  single clock; all state updates on rising edge.
REQ-005 i_rst_n  in  1  reset, synchronous, active-low.
REQ-006 i_start  in  1  frame start request; sampled in IDLE only.
REQ-007 i_frame_len  in  ADDR_W  symbols in the frame; latched on accepted start.
REQ-008 i_abort  in  1  synchronous abort of the current frame.
REQ-009 i_bm_valid  in  1  branch metrics for the current symbol are valid at the ACS inputs.
REQ-010 o_bm_ready  out  1  controller accepts a symbol this cycle.
REQ-011 i_acs_pm_0..3  in  PM_W each  new path metrics from the combinational ACS array.
REQ-012 i_acs_dec  in  4  per-state survivor decision bits from the ACS array.
REQ-013 o_pm_0..3  out  PM_W each  registered path metrics fed back to the ACS array.
REQ-014 o_sm_we, o_sm_addr[ADDR_W], o_sm_data[4]  out  survivor-memory write port.
REQ-015 o_busy  out  1  high in every state except IDLE.
REQ-016 o_done  out  1  frame complete; held until i_done_ack.
REQ-017 i_done_ack  in  1  traceback has taken the result.
REQ-018 o_best_state[2], o_best_pm[PM_W]  out  minimum-metric state and its metric, valid while o_done.

Function
REQ-019 FSM states SHALL be IDLE, INIT, RUN, FIND, DONE.
REQ-020 IDLE -> INIT when i_start=1; i_frame_len latched into len register; i_start ignored in all other states.
REQ-021 INIT SHALL last one cycle: o_pm_0 <= 0, o_pm_1..3 <= PM_INIT, symbol counter <= 0; then RUN if len != 0, else FIND.
REQ-022 o_bm_ready SHALL be 1 only in RUN (combinational on state).
REQ-023 A symbol is accepted when i_bm_valid & o_bm_ready; no accept -> all registers hold.
REQ-024 On accept: o_sm_we=1, o_sm_addr=counter, o_sm_data=i_acs_dec in the same cycle (combinational); at the edge, o_pm_n <= normalized i_acs_pm_n and counter increments.
REQ-025 Normalization: if MSB of all four i_acs_pm_n is 1, clear the MSB of all four before registering; otherwise register unchanged; no saturation or wrap detection beyond this.
REQ-026 RUN -> FIND on the edge accepting symbol number len (counter = len-1 at accept).
REQ-027 FIND SHALL last one cycle: select minimum of o_pm_0..3, ties to lowest index; register into o_best_state/o_best_pm; -> DONE.
REQ-028 DONE: o_done=1; i_done_ack=1 -> IDLE next edge, o_done falls; o_pm_n, o_best_* hold.
REQ-029 i_abort=1 in INIT/RUN/FIND -> IDLE next edge, no survivor write that cycle (o_sm_we forced 0), o_done stays 0; i_abort in IDLE/DONE ignored.
REQ-030 Latency with continuous i_bm_valid: start sampled cycle 0, INIT cycle 1, RUN cycles 2..len+1, FIND len+2, o_done high from cycle len+3.
REQ-031 o_sm_we SHALL be 0 outside RUN.

Reset
REQ-032 i_rst_n=0 at a rising edge, in any state including mid-frame: state IDLE, counter 0, len 0, o_pm_0..3 = 0, o_best_state = 0, o_best_pm = 0, o_done = 0, o_busy = 0.
REQ-033 Combinational outputs during reset: o_bm_ready = 0, o_sm_we = 0.

Verification
REQ-034 Start, len=3, valid continuous, ACS drives pm {1,5,6,7} then {2,3,7,8} then {4,3,9,9}, dec 4'hA,4'h5,4'hF -> writes addr 0,1,2 data A,5,F; o_done cycle 6; best_state 1, best_pm 3.
REQ-035 len=2, valid toggles 1,0,1 -> exactly two writes (addr 0,1); ready cycles without valid leave counter and o_pm_n unchanged; o_done cycle 6.
REQ-036 ACS drives pm {9,10,12,15} (PM_W=4) -> o_pm = {1,2,4,7}; then {8,9,3,10} -> registered unchanged.
REQ-037 len=0 -> INIT, FIND, DONE with no write; best_state 0, best_pm 0; tie {5,5,5,5} case -> best_state 0.
REQ-038 i_abort after 2 of 4 symbols -> IDLE next edge, no o_done; i_rst_n=0 mid-RUN -> all REQ-032 values next edge; i_start during RUN ignored.
